// File: rtl/otter_iobus_pkg.sv
// ---------------------------------------------------------------------------
// otter_iobus_pkg
//   Shared definitions for the OTTER IOBUS responder. It holds the register
//   byte offsets inside the 256-byte window, the TMR_CTRL bit positions, the
//   register-index enum and the offset decoder.
// ---------------------------------------------------------------------------
package otter_iobus_pkg;

   // Register byte offsets within the window
   localparam logic [7:0] OFS_SW       = 8'h00;
   localparam logic [7:0] OFS_BTN      = 8'h04;
   localparam logic [7:0] OFS_BTN_EDGE = 8'h08;
   localparam logic [7:0] OFS_LEDS     = 8'h20;
   localparam logic [7:0] OFS_SSEG     = 8'h40;
   localparam logic [7:0] OFS_TMR_CTRL = 8'h60;
   localparam logic [7:0] OFS_TMR_CMP  = 8'h64;
   localparam logic [7:0] OFS_TMR_CNT  = 8'h68;
   localparam logic [7:0] OFS_TMR_STAT = 8'h6C;

   // TMR_CTRL bit indices
   localparam int unsigned CTRL_EN     = 0;
   localparam int unsigned CTRL_RELOAD = 1;
   localparam int unsigned CTRL_IRQ_EN = 2;

   typedef enum logic [3:0] {
      REG_NONE,
      REG_SW,
      REG_BTN,
      REG_BTN_EDGE,
      REG_LEDS,
      REG_SSEG,
      REG_TMR_CTRL,
      REG_TMR_CMP,
      REG_TMR_CNT,
      REG_TMR_STAT
   } reg_idx_t;

   // Map a word offset (address bits [7:2]) to a register index
   function automatic reg_idx_t decode_offset(input logic [5:0] word_ofs);
      reg_idx_t idx;
      case ({word_ofs, 2'b00})
         OFS_SW:       idx = REG_SW;
         OFS_BTN:      idx = REG_BTN;
         OFS_BTN_EDGE: idx = REG_BTN_EDGE;
         OFS_LEDS:     idx = REG_LEDS;
         OFS_SSEG:     idx = REG_SSEG;
         OFS_TMR_CTRL: idx = REG_TMR_CTRL;
         OFS_TMR_CMP:  idx = REG_TMR_CMP;
         OFS_TMR_CNT:  idx = REG_TMR_CNT;
         OFS_TMR_STAT: idx = REG_TMR_STAT;
         default:      idx = REG_NONE;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/otter_iobus_responder_io_sync.sv
// ---------------------------------------------------------------------------
// io_sync
//   Multi-stage synchronizer for asynchronous board inputs. It also produces
//   a one-cycle rising-edge pulse taken from the synchronized value.
//   Ports:
//     clk   in   system clock
//     rst   in   asynchronous active-high reset
//     din   in   [WIDTH] asynchronous input
//     sync  out  [WIDTH] synchronized value (STAGES cycles of latency)
//     rise  out  [WIDTH] per-bit pulse, high while sync has just gone 0->1
// ---------------------------------------------------------------------------
module io_sync #(
   parameter int unsigned WIDTH  = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] stage_q [STAGES];
   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < STAGES; i++) stage_q[i] <= '0;
         prev_q <= '0;
      end else begin
         stage_q[0] <= din;
         for (int unsigned i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
         prev_q <= stage_q[STAGES-1];
      end
   end

   assign sync = stage_q[STAGES-1];
   assign rise = stage_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/otter_iobus_responder.sv
// ---------------------------------------------------------------------------
// otter_iobus_responder
//   Memory-mapped I/O target for the OTTER MCU IOBUS. It decodes a 256-byte
//   window at BASE_ADDR into switch/button inputs, LED and seven-segment
//   registers and an optional compare-match timer with an interrupt.
//   Writes take effect on the strobed edge. Reads are registered, so the
//   data appears one cycle after the address.
//   Optional feature: define IOBUS_TIMER_EN to build the timer (0x60-0x6C)
//   and INTR. Without it those offsets read 0, ignore writes, and INTR is 0.
//   Ports:
//     CLK, RST              clock / async active-high reset
//     IOBUS_ADDR/OUT/WR     byte address, write data, write strobe from MCU
//     IOBUS_IN              registered read data to MCU
//     SWITCHES[16]/BUTTONS[5] asynchronous board inputs
//     LEDS[16], SSEG[16]    output registers
//     INTR                  timer interrupt request (level)
// ---------------------------------------------------------------------------
module otter_iobus_responder
   import otter_iobus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1100_0000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] IOBUS_IN,
   input  logic [15:0] SWITCHES,
   input  logic [4:0]  BUTTONS,
   output logic [15:0] LEDS,
   output logic [15:0] SSEG,
   output logic        INTR
);

   logic        hit;
   reg_idx_t    sel;
   logic [15:0] sw_sync, sw_rise;
   logic [4:0]  btn_sync, btn_rise;
   logic [15:0] leds_q, sseg_q;
   logic [4:0]  btn_edge_q, btn_edge_next, btn_clr;
   logic [31:0] rd_data, iobus_in_q;

   assign hit = (IOBUS_ADDR[31:8] == BASE_ADDR[31:8]);
   assign sel = hit ? decode_offset(IOBUS_ADDR[7:2]) : REG_NONE;

   io_sync #(.WIDTH(16), .STAGES(SYNC_STAGES)) u_sw_sync (
      .clk  (CLK),
      .rst  (RST),
      .din  (SWITCHES),
      .sync (sw_sync),
      .rise (sw_rise)
   );

   io_sync #(.WIDTH(5), .STAGES(SYNC_STAGES)) u_btn_sync (
      .clk  (CLK),
      .rst  (RST),
      .din  (BUTTONS),
      .sync (btn_sync),
      .rise (btn_rise)
   );

   // A fresh edge wins over a W1C clear of the same bit
   always_comb begin
      btn_clr       = (IOBUS_WR && sel == REG_BTN_EDGE) ? IOBUS_OUT[4:0] : '0;
      btn_edge_next = (btn_edge_q & ~btn_clr) | btn_rise;
   end

`ifdef IOBUS_TIMER_EN
   logic [2:0]  tmr_ctrl_q;
   logic [31:0] tmr_cmp_q, tmr_cnt_q, tmr_cnt_next;
   logic        tmr_stat_q, tmr_stat_next, tmr_match;

   assign tmr_match = tmr_ctrl_q[CTRL_EN] && (tmr_cnt_q == tmr_cmp_q);

   // Priority: CNT write > reload-on-match > increment; match set > W1C
   always_comb begin
      tmr_cnt_next = tmr_cnt_q;
      if (IOBUS_WR && sel == REG_TMR_CNT)
         tmr_cnt_next = IOBUS_OUT;
      else if (tmr_match && tmr_ctrl_q[CTRL_RELOAD])
         tmr_cnt_next = '0;
      else if (tmr_ctrl_q[CTRL_EN])
         tmr_cnt_next = tmr_cnt_q + 32'd1;

      tmr_stat_next = tmr_stat_q;
      if (tmr_match)
         tmr_stat_next = 1'b1;
      else if (IOBUS_WR && sel == REG_TMR_STAT && IOBUS_OUT[0])
         tmr_stat_next = 1'b0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tmr_ctrl_q <= '0;
         tmr_cmp_q  <= '0;
         tmr_cnt_q  <= '0;
         tmr_stat_q <= 1'b0;
      end else begin
         if (IOBUS_WR && sel == REG_TMR_CTRL) tmr_ctrl_q <= IOBUS_OUT[2:0];
         if (IOBUS_WR && sel == REG_TMR_CMP)  tmr_cmp_q  <= IOBUS_OUT;
         tmr_cnt_q  <= tmr_cnt_next;
         tmr_stat_q <= tmr_stat_next;
      end
   end

   assign INTR = tmr_stat_q & tmr_ctrl_q[CTRL_IRQ_EN];
`else
   assign INTR = 1'b0;
`endif

   always_comb begin
      rd_data = '0;
      case (sel)
         REG_SW:       rd_data = {16'h0000, sw_sync};
         REG_BTN:      rd_data = {27'h0, btn_sync};
         REG_BTN_EDGE: rd_data = {27'h0, btn_edge_q};
         REG_LEDS:     rd_data = {16'h0000, leds_q};
         REG_SSEG:     rd_data = {16'h0000, sseg_q};
`ifdef IOBUS_TIMER_EN
         REG_TMR_CTRL: rd_data = {29'h0, tmr_ctrl_q};
         REG_TMR_CMP:  rd_data = tmr_cmp_q;
         REG_TMR_CNT:  rd_data = tmr_cnt_q;
         REG_TMR_STAT: rd_data = {31'h0, tmr_stat_q};
`endif
         default:      rd_data = '0;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         leds_q     <= '0;
         sseg_q     <= '0;
         btn_edge_q <= '0;
         iobus_in_q <= '0;
      end else begin
         if (IOBUS_WR && sel == REG_LEDS) leds_q <= IOBUS_OUT[15:0];
         if (IOBUS_WR && sel == REG_SSEG) sseg_q <= IOBUS_OUT[15:0];
         btn_edge_q <= btn_edge_next;
         iobus_in_q <= rd_data;
      end
   end

   assign LEDS     = leds_q;
   assign SSEG     = sseg_q;
   assign IOBUS_IN = iobus_in_q;

   // Byte-lane bits and the switch edge pulse are intentionally not used
   logic unused_bits;
`ifdef IOBUS_TIMER_EN
   assign unused_bits = ^{IOBUS_ADDR[1:0], sw_rise};
`else
   assign unused_bits = ^{IOBUS_ADDR[1:0], sw_rise, IOBUS_OUT[31:16]};
`endif

endmodule
